// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg: shared occupancy type and state encoding for pipeline stages
package core_pipe_pkg;
  typedef logic [1:0] pipe_occ_t;
  localparam pipe_occ_t OCC_EMPTY = 2'd0;
  localparam pipe_occ_t OCC_HALF = 2'd1;
  localparam pipe_occ_t OCC_FULL = 2'd2;
  // State codes equal the occupancy count so occupancy is a plain cast
  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_HALF = OCC_HALF,
    ST_FULL = OCC_FULL
  } pipe_state_t;
endpackage

// File: rtl/dff_en_w.sv
// dff_en_w: WIDTH-bit flop with synchronous reset to RESET_DATA and load enable
module dff_en_w #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input logic clk,
  input logic reset,
  input logic en,
  input logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  always_ff @(posedge clk) q_q <= reset ? RESET_DATA : en ? d_i : q_q;
  assign q_o = q_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: registered valid/ready pipeline stage with a one-entry skid buffer and flush
module pipe_stage_skid
  import core_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input logic clk,
  input logic reset,
  input logic flush,
  input logic in_valid,
  input logic [WIDTH-1:0] in_data,
  output logic in_ready,
  output logic out_valid,
  output logic [WIDTH-1:0] out_data,
  input logic out_ready,
  output pipe_occ_t occupancy
);
  pipe_state_t st_q, st_d;
  logic accept, emit, main_en, skid_en, main_from_skid, data_clr;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  // Both handshake outputs decode only the state register, so no out_ready -> in_ready path exists
  assign out_valid = st_q != ST_EMPTY;
  assign in_ready = st_q != ST_FULL;
  assign out_data = main_q;
  assign occupancy = pipe_occ_t'(st_q);
  assign accept = in_valid & in_ready;
  assign emit = out_valid & out_ready;
  assign data_clr = reset | (flush & CLEAR_ON_FLUSH);
  assign main_d = main_from_skid ? skid_q : in_data;
  always_ff @(posedge clk) st_q <= reset ? ST_EMPTY : st_d;
  always_comb begin
    st_d = st_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_from_skid = 1'b0;
    case (st_q)
      ST_EMPTY: begin
        st_d = accept ? ST_HALF : ST_EMPTY;
        main_en = accept;
      end
      ST_HALF: begin
        st_d = accept ? (emit ? ST_HALF : ST_FULL) : (emit ? ST_EMPTY : ST_HALF);
        main_en = accept & emit;
        skid_en = accept & !emit;
      end
      ST_FULL: begin
        st_d = emit ? ST_HALF : ST_FULL;
        main_en = emit;
        main_from_skid = emit;
      end
      default: st_d = ST_EMPTY;
    endcase
    // Squash: beats accepted this cycle are discarded and nothing new is loaded
    if (flush) begin
      st_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end
  dff_en_w #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_main (
    .clk(clk), .reset(data_clr), .en(main_en), .d_i(main_d), .q_o(main_q)
  );
  dff_en_w #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_skid (
    .clk(clk), .reset(data_clr), .en(skid_en), .d_i(in_data), .q_o(skid_q)
  );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a FIFO reference model
module tb_pipe_stage_skid;
  import core_pipe_pkg::*;
  localparam logic [31:0] RD = 32'hDEAD_BEEF;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, nc_in_ready, nc_out_valid;
  logic [31:0] out_data, nc_out_data;
  pipe_occ_t occupancy, nc_occupancy;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [31:0] idle = RD, idle_nc = RD;
  bit armed = 1'b0, acc, emt;
  always #5 clk = ~clk;
  pipe_stage_skid #(.WIDTH(32), .RESET_DATA(RD), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy)
  );
  pipe_stage_skid #(.WIDTH(32), .RESET_DATA(RD), .CLEAR_ON_FLUSH(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(nc_in_ready), .out_valid(nc_out_valid), .out_data(nc_out_data),
    .out_ready(out_ready), .occupancy(nc_occupancy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] d, input logic o);
    @(posedge clk);
    #1;
    reset = r;
    flush = f;
    in_valid = v;
    in_data = d;
    out_ready = o;
  endtask
  // Reference model: a FIFO of depth <= 2 plus the value the data register shows when empty
  always @(negedge clk) begin
    if (armed) begin
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("no_skid_only", 32'(in_ready | out_valid), 32'd1);
      chk("out_data", out_data, q.size() != 0 ? q[0] : idle);
      chk("nc_occupancy", 32'(nc_occupancy), 32'(q.size()));
      chk("nc_in_ready", 32'(nc_in_ready), 32'(q.size() < 2));
      chk("nc_out_valid", 32'(nc_out_valid), 32'(q.size() != 0));
      chk("nc_out_data", nc_out_data, q.size() != 0 ? q[0] : idle_nc);
    end
    if (reset) begin
      q.delete();
      idle = RD;
      idle_nc = RD;
      armed = 1'b1;
    end else if (armed) begin
      if (flush) begin
        idle_nc = q.size() != 0 ? q[0] : idle_nc;
        idle = RD;
        q.delete();
      end else begin
        acc = in_valid && q.size() < 2;
        emt = out_ready && q.size() != 0;
        if (emt) begin
          idle = q.pop_front();
          idle_nc = idle;
        end
        if (acc) q.push_back(in_data);
      end
    end
  end
  initial begin
    logic [31:0] sv [3];
    sv = '{32'h11, 32'h22, 32'h33};
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, RD);
    chk("rst_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, sv[i], 1);
      @(negedge clk);
      if (i > 0) chk("stream_data", out_data, sv[i-1]);
      if (i > 0) chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("stream_data", out_data, sv[2]);
    drive(0, 0, 1, 32'hA, 0);
    drive(0, 0, 1, 32'hB, 0);
    drive(0, 0, 1, 32'hC, 0);
    @(negedge clk);
    chk("skid_occ", 32'(occupancy), 32'd2);
    chk("skid_in_ready", 32'(in_ready), 32'd0);
    chk("skid_head", out_data, 32'hA);
    drive(0, 0, 1, 32'hC, 1);
    @(negedge clk);
    chk("stall_hold", out_data, 32'hA);
    drive(0, 0, 1, 32'hC, 1);
    @(negedge clk);
    chk("drain_b", out_data, 32'hB);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("drain_c", out_data, 32'hC);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_empty", 32'(occupancy), 32'd0);
    drive(0, 0, 1, 32'hA, 0);
    drive(0, 0, 1, 32'hB, 0);
    drive(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("pre_flush_occ", 32'(occupancy), 32'd2);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_full_valid", 32'(out_valid), 32'd0);
    chk("flush_full_occ", 32'(occupancy), 32'd0);
    chk("flush_full_in_ready", 32'(in_ready), 32'd1);
    chk("flush_full_data", out_data, RD);
    chk("flush_full_nc_data", nc_out_data, 32'hA);
    drive(0, 0, 1, 32'h66, 0);
    drive(0, 1, 1, 32'h55, 0);
    @(negedge clk);
    chk("flush_acc_pre", out_data, 32'h66);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_acc_occ", 32'(occupancy), 32'd0);
    chk("flush_acc_valid", 32'(out_valid), 32'd0);
    chk("flush_acc_data", out_data, RD);
    chk("flush_acc_nc_data", nc_out_data, 32'h66);
    chk("flush_acc_nc_valid", 32'(nc_out_valid), 32'd0);
    drive(0, 0, 1, 32'hA, 0);
    drive(0, 0, 1, 32'hB, 0);
    drive(1, 1, 1, 32'h77, 1);
    @(negedge clk);
    chk("pre_reset_occ", 32'(occupancy), 32'd2);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_full_occ", 32'(occupancy), 32'd0);
    chk("reset_full_data", out_data, RD);
    chk("reset_full_in_ready", 32'(in_ready), 32'd1);
    chk("reset_full_nc_data", nc_out_data, RD);
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(499) == 0, $urandom_range(63) == 0, $urandom_range(3) != 0,
            $urandom, $urandom_range(1) == 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
